// File: rtl/srio_axi_wr_arb_pkg.sv
// Shared encodings for the SRIO-PCIe bridge write-channel arbiter.
package srio_axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

endpackage

// File: rtl/srio_axi_wr_arb_if.sv
// AXI4 write address/data channel bundle (no B channel) used on both sides of the arbiter.
interface srio_axi_wr_arb_if #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 64
);
  logic [C_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [C_DATA_WIDTH-1:0] wdata;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  modport master (output awaddr, awlen, awvalid, wdata, wlast, wvalid,
                  input  awready, wready);
  modport slave  (input  awaddr, awlen, awvalid, wdata, wlast, wvalid,
                  output awready, wready);
endinterface

// File: rtl/srio_axi_wr_arb_rr_arb2.sv
// Two-request picker: a lone request wins; ties go to port 0 when fixed, else to the port not served last.
module rr_arb2
  import srio_axi_wr_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       prio_fixed_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = GRANT_NONE;
    case (req_i)
      2'b01:   gnt_o = GRANT_P0;
      2'b10:   gnt_o = GRANT_P1;
      2'b11:   gnt_o = (prio_fixed_i || last_grant_i) ? GRANT_P0 : GRANT_P1;
      default: gnt_o = GRANT_NONE;
    endcase
  end
endmodule

// File: rtl/srio_axi_wr_arb.sv
// Two-port AW/W arbiter for the bridge's single AXI write master; owns wlast generation.
module srio_axi_wr_arb
  import srio_axi_wr_arb_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 64,
  parameter int C_PRIO_FIXED = 0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  srio_axi_wr_arb_if.slave         s0,
  srio_axi_wr_arb_if.slave         s1,
  srio_axi_wr_arb_if.master        m_axi,
  output logic                     arb_busy,
  output logic [1:0]               arb_grant,
  output logic                     err_wlast
);
  arb_state_e              state_q, state_d;
  logic [1:0]              grant_q;
  logic                    last_grant_q;
  logic [7:0]              beat_cnt_q;
  logic                    err_q;
  logic [1:0]              pick;
  logic                    sel1;
  logic [C_ADDR_WIDTH-1:0] g_awaddr;
  logic [7:0]              g_awlen;
  logic                    g_awvalid;
  logic [C_DATA_WIDTH-1:0] g_wdata;
  logic                    g_wlast;
  logic                    g_wvalid;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    beat_last;

  rr_arb2 u_pick (
    .req_i        ({s1.awvalid, s0.awvalid}),
    .last_grant_i (last_grant_q),
    .prio_fixed_i (C_PRIO_FIXED != 0),
    .gnt_o        (pick)
  );

  assign sel1      = grant_q[1];
  assign g_awaddr  = sel1 ? s1.awaddr  : s0.awaddr;
  assign g_awlen   = sel1 ? s1.awlen   : s0.awlen;
  assign g_awvalid = sel1 ? s1.awvalid : s0.awvalid;
  assign g_wdata   = sel1 ? s1.wdata   : s0.wdata;
  assign g_wlast   = sel1 ? s1.wlast   : s0.wlast;
  assign g_wvalid  = sel1 ? s1.wvalid  : s0.wvalid;

  assign beat_last = (beat_cnt_q == 8'd0);
  assign aw_hs     = (state_q == S_ADDR) && g_awvalid && m_axi.awready;
  assign w_hs      = (state_q == S_DATA) && g_wvalid && m_axi.wready;

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (s0.awvalid || s1.awvalid) state_d = S_ADDR;
      S_ADDR:  if (aw_hs) state_d = S_DATA;
      S_DATA:  if (w_hs && beat_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Everything outside the granted phase is forced to zero, data lanes included.
  always_comb begin
    m_axi.awaddr  = '0;
    m_axi.awlen   = '0;
    m_axi.awvalid = 1'b0;
    m_axi.wdata   = '0;
    m_axi.wlast   = 1'b0;
    m_axi.wvalid  = 1'b0;
    s0.awready    = 1'b0;
    s1.awready    = 1'b0;
    s0.wready     = 1'b0;
    s1.wready     = 1'b0;
    case (state_q)
      S_ADDR: begin
        m_axi.awaddr  = g_awaddr;
        m_axi.awlen   = g_awlen;
        m_axi.awvalid = g_awvalid;
        s0.awready    = m_axi.awready && grant_q[0];
        s1.awready    = m_axi.awready && grant_q[1];
      end
      S_DATA: begin
        m_axi.wdata   = g_wdata;
        m_axi.wlast   = beat_last;
        m_axi.wvalid  = g_wvalid;
        s0.wready     = m_axi.wready && grant_q[0];
        s1.wready     = m_axi.wready && grant_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      grant_q      <= GRANT_NONE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      err_q <= w_hs && (g_wlast != beat_last);
      if (state_q == S_IDLE && (s0.awvalid || s1.awvalid)) grant_q <= pick;
      if (aw_hs) beat_cnt_q <= g_awlen;
      if (w_hs) begin
        if (beat_last) begin
          grant_q      <= GRANT_NONE;
          last_grant_q <= grant_q[1];
        end else begin
          beat_cnt_q <= beat_cnt_q - 8'd1;
        end
      end
    end
  end

  assign arb_busy  = (state_q != S_IDLE);
  assign arb_grant = grant_q;
  assign err_wlast = err_q;

endmodule

// File: tb/tb_srio_axi_wr_arb.sv
// Scoreboard bench for srio_axi_wr_arb: round-robin instance plus a fixed-priority twin on mirrored inputs.
module tb_srio_axi_wr_arb;
  import srio_axi_wr_arb_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic       arb_busy, f_arb_busy;
  logic [1:0] arb_grant, f_arb_grant;
  logic       err_wlast, f_err_wlast;

  always #5 aclk = ~aclk;

  srio_axi_wr_arb_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64)) s0_if ();
  srio_axi_wr_arb_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64)) s1_if ();
  srio_axi_wr_arb_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64)) m_if ();
  srio_axi_wr_arb_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64)) f_s0 ();
  srio_axi_wr_arb_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64)) f_s1 ();
  srio_axi_wr_arb_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64)) f_m ();

  srio_axi_wr_arb #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64), .C_PRIO_FIXED(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .s0(s0_if), .s1(s1_if), .m_axi(m_if),
    .arb_busy(arb_busy), .arb_grant(arb_grant), .err_wlast(err_wlast));

  srio_axi_wr_arb #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(64), .C_PRIO_FIXED(1)) dut_fixed (
    .aclk(aclk), .aresetn(aresetn), .s0(f_s0), .s1(f_s1), .m_axi(f_m),
    .arb_busy(f_arb_busy), .arb_grant(f_arb_grant), .err_wlast(f_err_wlast));

  // The fixed-priority twin sees exactly the requests and readies of the main instance.
  assign f_s0.awaddr = s0_if.awaddr;  assign f_s1.awaddr = s1_if.awaddr;
  assign f_s0.awlen  = s0_if.awlen;   assign f_s1.awlen  = s1_if.awlen;
  assign f_s0.awvalid = s0_if.awvalid; assign f_s1.awvalid = s1_if.awvalid;
  assign f_s0.wdata  = s0_if.wdata;   assign f_s1.wdata  = s1_if.wdata;
  assign f_s0.wlast  = s0_if.wlast;   assign f_s1.wlast  = s1_if.wlast;
  assign f_s0.wvalid = s0_if.wvalid;  assign f_s1.wvalid = s1_if.wvalid;
  assign f_m.awready = m_if.awready;
  assign f_m.wready  = m_if.wready;

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] grant; } aw_t;
  typedef struct { logic [63:0] data; logic last; } w_t;

  aw_t exp_aw[$];
  w_t  exp_w[$];

  int n_tests = 0;
  int n_fail  = 0;

  // requester model state, one entry per port
  bit          pend[2];
  bit          aw_done[2];
  int          beat[2];
  logic [7:0]  len[2];
  logic [31:0] addr[2];
  int          bad[2];
  bit          wr_toggle = 1'b0;

  int         first_aw_cyc, prev_w_cyc, gap_last, run_w, err_cnt;
  logic [1:0] cur_grant;

  function automatic logic [63:0] mk(input int p, input logic [31:0] a, input int b);
    logic [3:0]  pp;
    logic [31:0] bb;
    pp = 4'(p);
    bb = 32'(b);
    return {pp, a[27:0], bb};
  endfunction

  function automatic logic wl(input int p);
    return (beat[p] == int'(len[p])) || (beat[p] == bad[p]);
  endfunction

  task automatic drive_inputs(input int cyc);
    s0_if.awvalid = pend[0] && !aw_done[0];
    s0_if.awaddr  = addr[0];
    s0_if.awlen   = len[0];
    s0_if.wvalid  = pend[0] && aw_done[0];
    s0_if.wdata   = mk(0, addr[0], beat[0]);
    s0_if.wlast   = wl(0);
    s1_if.awvalid = pend[1] && !aw_done[1];
    s1_if.awaddr  = addr[1];
    s1_if.awlen   = len[1];
    s1_if.wvalid  = pend[1] && aw_done[1];
    s1_if.wdata   = mk(1, addr[1], beat[1]);
    s1_if.wlast   = wl(1);
    m_if.awready  = 1'b1;
    m_if.wready   = wr_toggle ? ((cyc % 2) == 0) : 1'b1;
  endtask

  task automatic arm(input int p, input logic [31:0] a, input logic [7:0] l, input int b);
    pend[p] = 1'b1; aw_done[p] = 1'b0; beat[p] = 0;
    addr[p] = a; len[p] = l; bad[p] = b;
  endtask

  task automatic expect_burst(input int p, input logic [31:0] a, input logic [7:0] l);
    aw_t ai;
    w_t  wi;
    ai.addr = a; ai.len = l; ai.grant = (p == 1) ? GRANT_P1 : GRANT_P0;
    exp_aw.push_back(ai);
    for (int b = 0; b <= int'(l); b++) begin
      wi.data = mk(p, a, b);
      wi.last = (b == int'(l));
      exp_w.push_back(wi);
    end
  endtask

  task automatic clear_req();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; aw_done[p] = 1'b0; beat[p] = 0; bad[p] = -1;
      len[p] = 8'd0; addr[p] = 32'd0;
    end
  endtask

  task automatic do_reset();
    clear_req();
    wr_toggle = 1'b0;
    drive_inputs(0);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  // Runs both requesters against the DUT until their bursts finish, the budget runs out,
  // or stop_w W beats have been accepted (0 = no such stop).
  task automatic drive_bursts(input int budget, input int stop_w);
    int  cyc;
    bit  aw_hs[2];
    bit  w_hs[2];
    bit  exp_err;
    aw_t ai;
    w_t  wi;
    cyc = 0; run_w = 0; first_aw_cyc = -1; prev_w_cyc = -1; gap_last = -1; err_cnt = 0;
    drive_inputs(0);
    while ((pend[0] || pend[1]) && cyc < budget && (stop_w == 0 || run_w < stop_w)) begin
      @(negedge aclk);
      if (m_if.awvalid && m_if.awready) begin
        if (first_aw_cyc < 0) first_aw_cyc = cyc;
        if (prev_w_cyc >= 0) gap_last = cyc - prev_w_cyc;
        n_tests++;
        if (exp_aw.size() == 0) begin
          n_fail++;
          $display("FAIL aw_unexpected: addr=%h with empty scoreboard", m_if.awaddr);
        end else begin
          ai = exp_aw.pop_front();
          cur_grant = ai.grant;
          if (m_if.awaddr !== ai.addr || m_if.awlen !== ai.len || arb_grant !== ai.grant) begin
            n_fail++;
            $display("FAIL aw_match: got addr=%h len=%0d grant=%b, want addr=%h len=%0d grant=%b",
                     m_if.awaddr, m_if.awlen, arb_grant, ai.addr, ai.len, ai.grant);
          end
        end
      end
      if (m_if.wvalid && m_if.wready) begin
        run_w++;
        prev_w_cyc = cyc;
        n_tests++;
        if (exp_w.size() == 0) begin
          n_fail++;
          $display("FAIL w_unexpected: data=%h with empty scoreboard", m_if.wdata);
        end else begin
          wi = exp_w.pop_front();
          if (m_if.wdata !== wi.data || m_if.wlast !== wi.last || arb_grant !== cur_grant) begin
            n_fail++;
            $display("FAIL w_match: got data=%h last=%b grant=%b, want data=%h last=%b grant=%b",
                     m_if.wdata, m_if.wlast, arb_grant, wi.data, wi.last, cur_grant);
          end
        end
      end
      aw_hs[0] = s0_if.awvalid && s0_if.awready;
      aw_hs[1] = s1_if.awvalid && s1_if.awready;
      w_hs[0]  = s0_if.wvalid && s0_if.wready;
      w_hs[1]  = s1_if.wvalid && s1_if.wready;
      n_tests++;
      if ((aw_hs[0] && aw_hs[1]) || (w_hs[0] && w_hs[1]) ||
          (s0_if.wready && !aw_done[0]) || (s1_if.wready && !aw_done[1])) begin
        n_fail++;
        $display("FAIL ready_leak: s0 aw/w=%b%b s1 aw/w=%b%b grant=%b",
                 s0_if.awready, s0_if.wready, s1_if.awready, s1_if.wready, arb_grant);
      end
      exp_err = (w_hs[0] && beat[0] == bad[0]) || (w_hs[1] && beat[1] == bad[1]);
      @(posedge aclk); #1;
      cyc++;
      if (err_wlast === 1'b1) err_cnt++;
      n_tests++;
      if (err_wlast !== exp_err) begin
        n_fail++;
        $display("FAIL err_wlast: got %b want %b at cycle %0d", err_wlast, exp_err, cyc);
      end
      for (int p = 0; p < 2; p++) begin
        if (aw_hs[p]) aw_done[p] = 1'b1;
        if (w_hs[p]) begin
          if (beat[p] == int'(len[p])) begin
            pend[p] = 1'b0; aw_done[p] = 1'b0; beat[p] = 0;
          end else begin
            beat[p]++;
          end
        end
      end
      drive_inputs(cyc);
    end
    if ((pend[0] || pend[1]) && !(stop_w != 0 && run_w >= stop_w)) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: bursts pending after %0d cycles, got done=0 want done=1", cyc);
    end
  endtask

  task automatic check_drained(input string tag);
    @(negedge aclk);
    n_tests++;
    if (exp_aw.size() != 0 || exp_w.size() != 0 || arb_busy !== 1'b0 || arb_grant !== GRANT_NONE) begin
      n_fail++;
      $display("FAIL %s_drain: aw_left=%0d w_left=%0d busy=%b grant=%b, want 0 0 0 00",
               tag, exp_aw.size(), exp_w.size(), arb_busy, arb_grant);
    end
    @(posedge aclk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [11:0] v;
    v = {arb_busy, arb_grant, err_wlast, m_if.awvalid, m_if.wvalid, m_if.wlast,
         s0_if.awready, s0_if.wready, s1_if.awready, s1_if.wready, |m_if.awaddr};
    n_tests++;
    if (v !== 12'd0) begin
      n_fail++;
      $display("FAIL %s_outputs: got %b want all zero", tag, v);
    end
  endtask

  task automatic test_reset();
    clear_req();
    arm(0, 32'h0000_0500, 8'd1, -1);
    aw_done[0] = 1'b1;
    drive_inputs(0);
    s0_if.awvalid = 1'b1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    check_all_zero("reset");
    @(posedge aclk); #1;
    do_reset();
  endtask

  task automatic test_single();
    arm(0, 32'h0000_1000, 8'd3, -1);
    expect_burst(0, 32'h0000_1000, 8'd3);
    drive_bursts(100, 0);
    n_tests++;
    if (first_aw_cyc != 1 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL single_latency: aw_cycle=%0d err_pulses=%0d, want 1 and 0", first_aw_cyc, err_cnt);
    end
    check_drained("single");
  endtask

  task automatic test_tie_rr();
    do_reset();
    arm(0, 32'h0000_2000, 8'd1, -1);
    arm(1, 32'h0000_3000, 8'd1, -1);
    expect_burst(0, 32'h0000_2000, 8'd1);
    expect_burst(1, 32'h0000_3000, 8'd1);
    drive_bursts(100, 0);
    n_tests++;
    if (gap_last != 2) begin
      n_fail++;
      $display("FAIL tie_bubble: aw gap=%0d want 2", gap_last);
    end
    check_drained("tie1");
    arm(0, 32'h0000_2100, 8'd0, -1);
    expect_burst(0, 32'h0000_2100, 8'd0);
    drive_bursts(50, 0);
    arm(0, 32'h0000_2200, 8'd2, -1);
    arm(1, 32'h0000_3200, 8'd2, -1);
    expect_burst(1, 32'h0000_3200, 8'd2);
    expect_burst(0, 32'h0000_2200, 8'd2);
    drive_bursts(100, 0);
    check_drained("tie2");
  endtask

  task automatic test_fixed_prio();
    logic [1:0] eg;
    int         lg, f_cnt, r_cnt;
    do_reset();
    s0_if.awaddr = 32'h0000_4000; s0_if.awlen = 8'd0; s0_if.awvalid = 1'b1;
    s0_if.wvalid = 1'b1; s0_if.wlast = 1'b1; s0_if.wdata = 64'h0;
    s1_if.awaddr = 32'h0000_5000; s1_if.awlen = 8'd0; s1_if.awvalid = 1'b1;
    s1_if.wvalid = 1'b1; s1_if.wlast = 1'b1; s1_if.wdata = 64'h1;
    m_if.awready = 1'b1; m_if.wready = 1'b1;
    lg = 1; f_cnt = 0; r_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge aclk);
      if (f_m.awvalid && f_m.awready) begin
        f_cnt++;
        n_tests++;
        if (f_arb_grant !== GRANT_P0 || f_m.awaddr !== 32'h0000_4000) begin
          n_fail++;
          $display("FAIL fixed_grant: got grant=%b addr=%h want 01 00004000", f_arb_grant, f_m.awaddr);
        end
      end
      if (m_if.awvalid && m_if.awready) begin
        r_cnt++;
        eg = (lg == 1) ? GRANT_P0 : GRANT_P1;
        n_tests++;
        if (arb_grant !== eg) begin
          n_fail++;
          $display("FAIL rr_alternate: got grant=%b want %b", arb_grant, eg);
        end
        lg = (eg == GRANT_P1) ? 1 : 0;
      end
      @(posedge aclk); #1;
    end
    n_tests++;
    if (f_cnt != 10 || r_cnt != 10) begin
      n_fail++;
      $display("FAIL prio_count: got fixed=%0d rr=%0d want 10 10", f_cnt, r_cnt);
    end
    do_reset();
  endtask

  task automatic test_wready_toggle();
    wr_toggle = 1'b1;
    arm(0, 32'h0000_6000, 8'd7, -1);
    expect_burst(0, 32'h0000_6000, 8'd7);
    drive_bursts(200, 0);
    n_tests++;
    if (run_w != 8) begin
      n_fail++;
      $display("FAIL toggle_beats: got %0d handshakes want 8", run_w);
    end
    wr_toggle = 1'b0;
    check_drained("toggle");
  endtask

  task automatic test_wlast_err();
    arm(1, 32'h0000_7000, 8'd3, 1);
    expect_burst(1, 32'h0000_7000, 8'd3);
    drive_bursts(100, 0);
    n_tests++;
    if (err_cnt != 1 || run_w != 4) begin
      n_fail++;
      $display("FAIL wlast_err: got pulses=%0d beats=%0d want 1 and 4", err_cnt, run_w);
    end
    check_drained("wlast_err");
  endtask

  task automatic test_reset_mid();
    arm(0, 32'h0000_8000, 8'd3, -1);
    expect_burst(0, 32'h0000_8000, 8'd3);
    drive_bursts(100, 1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    check_all_zero("reset_mid");
    @(posedge aclk); #1;
    exp_aw.delete();
    exp_w.delete();
    do_reset();
    arm(0, 32'h0000_9000, 8'd1, -1);
    expect_burst(0, 32'h0000_9000, 8'd1);
    drive_bursts(100, 0);
    n_tests++;
    if (first_aw_cyc != 1) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: aw_cycle=%0d want 1", first_aw_cyc);
    end
    check_drained("reset_mid");
  endtask

  initial begin
    clear_req();
    drive_inputs(0);
    repeat (2) @(posedge aclk);
    #1;
    test_reset();
    test_single();
    test_tie_rr();
    test_fixed_prio();
    test_wready_toggle();
    test_wlast_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
